axi_master_arbiter_r: RTL
=========================

Name: axi_master_arbiter_r

Overview:
- Two-master AXI4 read-channel arbiter.
- Sits directly upstream of the slave-side read mux and drives its internal s2m_* AR/R interface.
- Selects one master at a time by round-robin and forwards that master's AR request.
- Holds the grant through the whole read burst, routing R beats back to the owning master until the RLAST handshake completes.
- Supports a single outstanding transaction.

Parameters:
DATA_WIDTH, 1024, R data width
ADDR_WIDTH, 64, AR address width
ID_WIDTH, 8, AR/R ID width, passed through unchanged
USER_WIDTH, 8, ARUSER/RUSER width

Ports:
ACLK  input  1  clock; all state updates on the rising edge
ARESETn  input  1  reset, asynchronous, active-low
sN_ARVALID (N=0,1)  input  1  master N address valid
sN_ARREADY  output  1  master N address ready
sN_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  input  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  master N AR payload
sN_RID/RDATA/RRESP/RLAST/RUSER  output  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH  master N R payload
sN_RVALID  output  1  master N read-data valid
sN_RREADY  input  1  master N read-data ready
s2m_ARVALID  output  1  AR valid toward slave mux
s2m_ARREADY  input  1  AR ready from slave mux
s2m_ARID..s2m_ARUSER  output  same widths as sN_AR*  forwarded AR payload
s2m_RID/RDATA/RRESP/RLAST/RUSER  input  same widths as sN_R*  R payload from slave mux
s2m_RVALID  input  1  R valid from slave mux
s2m_RREADY  output  1  R ready toward slave mux
grant_o  output  1  current owner index; debug/observability

Behaviour:
- Registered state:
  - state: IDLE, ADDR, DATA
  - grant: 1 bit
  - last: 1 bit, index of the previous winner
- Reset (ARESETn low, asynchronous):
  - state=IDLE, grant=0, last=1, so master 0 has priority first.
- Outputs while reset is asserted and in IDLE:
  - s2m_ARVALID=0, s2m_RREADY=0.
  - s0/s1_ARREADY=0, s0/s1_RVALID=0.
  - All s2m_AR* payload outputs and sN_R* payload outputs are 0.
  - grant_o=grant.
- IDLE:
  - If exactly one sN_ARVALID=1: grant<=N, go to ADDR.
  - If both are 1: grant<=~last, go to ADDR.
  - If neither: stay in IDLE.
  - Arbitration costs one cycle; no AR is forwarded in IDLE.
- ADDR:
  - s2m_ARVALID = s[grant]_ARVALID; s2m_AR* payload = s[grant] payload.
  - s[grant]_ARREADY = s2m_ARREADY; the other master's ARREADY=0.
  - On s2m_ARVALID & s2m_ARREADY: go to DATA.
  - A master that deasserts ARVALID before the handshake is an AXI protocol violation. The arbiter stays in ADDR; no recovery is required.
- DATA:
  - s[grant]_R* payload and s[grant]_RVALID = s2m_R* and s2m_RVALID.
  - s2m_RREADY = s[grant]_RREADY.
  - Non-granted master: RVALID=0, R payload=0.
  - Both masters have ARREADY=0, and s2m_ARVALID=0.
  - On s2m_RVALID & s2m_RREADY & s2m_RLAST: last<=grant, go to IDLE.
  - Beats without RLAST keep the arbiter in DATA for any ARLEN (1..256 beats).
- All forwarding in ADDR/DATA is combinational from the registered grant/state. There is zero added latency on AR and R once granted.
- Back-to-back operation:
  - The earliest next AR forward is the cycle after return to IDLE plus the arbitration cycle.
  - Minimum gap from the final RLAST handshake to the next s2m_ARVALID is 2 cycles.
- Fairness:
  - With both masters continuously requesting, grants alternate 0,1,0,1...
  - A lone requester wins repeatedly regardless of last.
- RVALID from the slave side while in IDLE/ADDR is ignored: s2m_RREADY=0 and no master RVALID.
- Reset asserted mid-burst: immediate return to reset values. In-flight beats are dropped; the slave side is reset by the same ARESETn.

Test Plan:
1. Reset with both masters requesting:
   - Stimulus: release ARESETn, then s0_ARVALID=s1_ARVALID=1.
   - Required: grant_o=0 in cycle 2; s2m_ARADDR=s0_ARADDR; s1_ARREADY stays 0.
2. Single-beat read:
   - Stimulus: master 1 alone, ARLEN=0, s2m_ARREADY=1; slave returns RDATA=0xA5, RLAST=1, RID=0x3C.
   - Required: s1_RVALID=1, s1_RDATA=0xA5, s1_RID=0x3C; s0_RVALID=0; arbiter back in IDLE the cycle after the handshake.
3. Burst with backpressure:
   - Stimulus: ARLEN=3; s0_RREADY toggles 1,0,1,0,...
   - Required: exactly 4 beats accepted; s2m_RREADY mirrors s0_RREADY; grant held until the 4th beat with RLAST.
4. Round-robin fairness:
   - Stimulus: both masters request continuously for 4 single-beat reads.
   - Required: grant sequence 0,1,0,1; 2-cycle gap from each RLAST handshake to the next s2m_ARVALID.
5. AR stall:
   - Stimulus: s2m_ARREADY=0 for 5 cycles, then 1.
   - Required: s2m_ARVALID and payload stable for all 6 cycles; transition to DATA only after the handshake.
6. Reset mid-burst:
   - Stimulus: assert ARESETn low after beat 2 of an ARLEN=7 burst.
   - Required: all valids/readies 0 immediately, without waiting for a clock edge; after release, grant returns to master 0 first.

Source files
------------

// File: rtl/axi_master_arbiter_r.sv
// Two-master AXI4 read-channel arbiter: round-robin grant held from AR handshake
// through the RLAST beat, one outstanding transaction, zero-latency forwarding.
module axi_master_arbiter_r #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // master 0
    input  logic                  s0_ARVALID,
    output logic                  s0_ARREADY,
    input  logic [ID_WIDTH-1:0]   s0_ARID,
    input  logic [ADDR_WIDTH-1:0] s0_ARADDR,
    input  logic [7:0]            s0_ARLEN,
    input  logic [2:0]            s0_ARSIZE,
    input  logic [1:0]            s0_ARBURST,
    input  logic                  s0_ARLOCK,
    input  logic [3:0]            s0_ARCACHE,
    input  logic [2:0]            s0_ARPROT,
    input  logic [3:0]            s0_ARQOS,
    input  logic [3:0]            s0_ARREGION,
    input  logic [USER_WIDTH-1:0] s0_ARUSER,
    output logic [ID_WIDTH-1:0]   s0_RID,
    output logic [DATA_WIDTH-1:0] s0_RDATA,
    output logic [1:0]            s0_RRESP,
    output logic                  s0_RLAST,
    output logic [USER_WIDTH-1:0] s0_RUSER,
    output logic                  s0_RVALID,
    input  logic                  s0_RREADY,
    // master 1
    input  logic                  s1_ARVALID,
    output logic                  s1_ARREADY,
    input  logic [ID_WIDTH-1:0]   s1_ARID,
    input  logic [ADDR_WIDTH-1:0] s1_ARADDR,
    input  logic [7:0]            s1_ARLEN,
    input  logic [2:0]            s1_ARSIZE,
    input  logic [1:0]            s1_ARBURST,
    input  logic                  s1_ARLOCK,
    input  logic [3:0]            s1_ARCACHE,
    input  logic [2:0]            s1_ARPROT,
    input  logic [3:0]            s1_ARQOS,
    input  logic [3:0]            s1_ARREGION,
    input  logic [USER_WIDTH-1:0] s1_ARUSER,
    output logic [ID_WIDTH-1:0]   s1_RID,
    output logic [DATA_WIDTH-1:0] s1_RDATA,
    output logic [1:0]            s1_RRESP,
    output logic                  s1_RLAST,
    output logic [USER_WIDTH-1:0] s1_RUSER,
    output logic                  s1_RVALID,
    input  logic                  s1_RREADY,
    // slave-side mux
    output logic                  s2m_ARVALID,
    input  logic                  s2m_ARREADY,
    output logic [ID_WIDTH-1:0]   s2m_ARID,
    output logic [ADDR_WIDTH-1:0] s2m_ARADDR,
    output logic [7:0]            s2m_ARLEN,
    output logic [2:0]            s2m_ARSIZE,
    output logic [1:0]            s2m_ARBURST,
    output logic                  s2m_ARLOCK,
    output logic [3:0]            s2m_ARCACHE,
    output logic [2:0]            s2m_ARPROT,
    output logic [3:0]            s2m_ARQOS,
    output logic [3:0]            s2m_ARREGION,
    output logic [USER_WIDTH-1:0] s2m_ARUSER,
    input  logic [ID_WIDTH-1:0]   s2m_RID,
    input  logic [DATA_WIDTH-1:0] s2m_RDATA,
    input  logic [1:0]            s2m_RRESP,
    input  logic                  s2m_RLAST,
    input  logic [USER_WIDTH-1:0] s2m_RUSER,
    input  logic                  s2m_RVALID,
    output logic                  s2m_RREADY,
    output logic                  grant_o
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } ar_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } r_t;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   last, last_nxt;

    logic [1:0] arvalid, arready, rvalid, rready;
    ar_t  [1:0] ar_in;
    ar_t        ar_out;
    r_t         r_in;
    r_t   [1:0] r_out;

    assign arvalid = {s1_ARVALID, s0_ARVALID};
    assign rready  = {s1_RREADY, s0_RREADY};
    assign ar_in[0] = {s0_ARID, s0_ARADDR, s0_ARLEN, s0_ARSIZE, s0_ARBURST, s0_ARLOCK,
                       s0_ARCACHE, s0_ARPROT, s0_ARQOS, s0_ARREGION, s0_ARUSER};
    assign ar_in[1] = {s1_ARID, s1_ARADDR, s1_ARLEN, s1_ARSIZE, s1_ARBURST, s1_ARLOCK,
                       s1_ARCACHE, s1_ARPROT, s1_ARQOS, s1_ARREGION, s1_ARUSER};
    assign r_in     = {s2m_RID, s2m_RDATA, s2m_RRESP, s2m_RLAST, s2m_RUSER};

    // last resets to 1 so master 0 wins the first contended arbitration
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (|arvalid) begin
                    grant_nxt = (&arvalid) ? ~last : arvalid[1];
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (arvalid[grant] && s2m_ARREADY) state_nxt = DATA;
            end
            DATA: begin
                if (s2m_RVALID && rready[grant] && s2m_RLAST) begin
                    last_nxt  = grant;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Forwarding is purely combinational off the registered state/grant
    always_comb begin
        arready     = '0;
        rvalid      = '0;
        r_out       = '0;
        ar_out      = '0;
        s2m_ARVALID = 1'b0;
        s2m_RREADY  = 1'b0;
        case (state)
            ADDR: begin
                s2m_ARVALID    = arvalid[grant];
                ar_out         = ar_in[grant];
                arready[grant] = s2m_ARREADY;
            end
            DATA: begin
                rvalid[grant] = s2m_RVALID;
                r_out[grant]  = r_in;
                s2m_RREADY    = rready[grant];
            end
            default: ;
        endcase
    end

    assign {s2m_ARID, s2m_ARADDR, s2m_ARLEN, s2m_ARSIZE, s2m_ARBURST, s2m_ARLOCK,
            s2m_ARCACHE, s2m_ARPROT, s2m_ARQOS, s2m_ARREGION, s2m_ARUSER} = ar_out;
    assign {s0_RID, s0_RDATA, s0_RRESP, s0_RLAST, s0_RUSER} = r_out[0];
    assign {s1_RID, s1_RDATA, s1_RRESP, s1_RLAST, s1_RUSER} = r_out[1];
    assign s0_ARREADY = arready[0];
    assign s1_ARREADY = arready[1];
    assign s0_RVALID  = rvalid[0];
    assign s1_RVALID  = rvalid[1];
    assign grant_o    = grant;

endmodule
